// File: rtl/tdc_event_fifo_if.sv
// TDC event bus between the TDC core and its downstream consumer.
// The consumer side (external) samples the event fields and returns clear.
interface TDCInterface;
    logic [31:0] timestamp;
    logic [31:0] timeOverThreshold;
    logic [3:0]  chan;
    logic        hasEvent;
    logic        clear;

    modport external (
        input  timestamp,
        input  timeOverThreshold,
        input  chan,
        input  hasEvent,
        output clear
    );

    modport core (
        output timestamp,
        output timeOverThreshold,
        output chan,
        output hasEvent,
        input  clear
    );
endinterface

// File: rtl/tdc_event_fifo.sv
// Captures TDC events into a FIFO and serves them as three 32-bit readout words each.
// Optional time-over-threshold filter enabled by defining TDC_FIFO_TOT_FILTER_EN.
module tdc_event_fifo #(
    parameter int unsigned DEPTH   = 16,
    parameter logic [31:0] MIN_TOT = 32'd4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    TDCInterface.external            tdc,
    input  logic                     rd_req,
    output logic [31:0]              rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     fifo_full,
    output logic                     fifo_empty,
    output logic [15:0]              filtered_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACK  = 1'b1
    } cap_state_e;

    cap_state_e        state_r;
    cap_state_e        state_nxt_s;
    logic              accept_s;
    logic              push_s;
    logic              pop_s;
    logic              filt_s;
    logic              clear_r;

    logic [67:0]       mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [LW-1:0]     level_r;
    logic [LW-1:0]     level_nxt_s;
    logic              full_r;
    logic              empty_r;

    logic [1:0]        idx_r;
    logic [1:0]        idx_nxt_s;
    logic [67:0]       head_s;
    logic [31:0]       word_s;
    logic [31:0]       rd_data_r;
    logic              rd_valid_r;

`ifdef TDC_FIFO_TOT_FILTER_EN
    // Short pulses are treated as noise and dropped after acknowledgement.
    always_comb begin
        filt_s = (tdc.timeOverThreshold < MIN_TOT);
    end
`else
    logic unused_min_tot_s;
    assign unused_min_tot_s = ^MIN_TOT;

    // Without the filter every event is stored.
    always_comb begin
        filt_s = 1'b0;
    end
`endif

    // A filtered event needs no room, so it is acknowledged even when full.
    always_comb begin
        accept_s = tdc.hasEvent && (!full_r || filt_s);
    end

    // Capture FSM state register; clear mirrors the next state so it is registered.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= IDLE;
            clear_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            clear_r <= (state_nxt_s == ACK);
        end
    end

    // Capture FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ACK;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACK: begin
                if (!tdc.hasEvent) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = ACK;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Capture FSM outputs: write strobe for the FIFO.
    always_comb begin
        push_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s && !filt_s) begin
                    push_s = 1'b1;
                end else begin
                    push_s = 1'b0;
                end
            end
            ACK:     push_s = 1'b0;
            default: push_s = 1'b0;
        endcase
    end

    assign tdc.clear = clear_r;

    // Entry storage; pointers alone define validity so no reset is needed here.
    always_ff @(posedge clk) begin
        if (reset_n && push_s) begin
            mem_r[wr_ptr_r] <= {tdc.chan, tdc.timeOverThreshold, tdc.timestamp};
        end
    end

    // Readout word selection and index sequencing.
    always_comb begin
        head_s    = mem_r[rd_ptr_r];
        word_s    = 32'h0000_0000;
        idx_nxt_s = idx_r;
        pop_s     = 1'b0;
        case (idx_r)
            2'd0: begin
                if (empty_r) begin
                    word_s = 32'h0000_0000;
                end else begin
                    word_s = {8'hA5, head_s[67:64], 4'h0, 16'(level_r)};
                end
            end
            2'd1:    word_s = head_s[31:0];
            2'd2:    word_s = head_s[63:32];
            default: word_s = 32'h0000_0000;
        endcase
        if (rd_req && !(empty_r && (idx_r == 2'd0))) begin
            if (idx_r == 2'd2) begin
                idx_nxt_s = 2'd0;
                pop_s     = 1'b1;
            end else begin
                idx_nxt_s = idx_r + 2'd1;
                pop_s     = 1'b0;
            end
        end else begin
            idx_nxt_s = idx_r;
            pop_s     = 1'b0;
        end
    end

    // Occupancy bookkeeping; a same-edge push and pop cancel out.
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   level_nxt_s = level_r + LW'(1);
            2'b01:   level_nxt_s = level_r - LW'(1);
            default: level_nxt_s = level_r;
        endcase
    end

    // FIFO pointers, level, flags and word index.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
            idx_r    <= 2'd0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            level_r <= level_nxt_s;
            full_r  <= (level_nxt_s == LW'(DEPTH));
            empty_r <= (level_nxt_s == LW'(0));
            idx_r   <= idx_nxt_s;
        end
    end

    // Registered readout port; data holds between requests.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_valid_r <= 1'b0;
            rd_data_r  <= 32'h0000_0000;
        end else begin
            rd_valid_r <= rd_req;
            if (rd_req) begin
                rd_data_r <= word_s;
            end else begin
                rd_data_r <= rd_data_r;
            end
        end
    end

`ifdef TDC_FIFO_TOT_FILTER_EN
    logic [15:0] filt_cnt_r;

    // Saturating count of events acknowledged but dropped.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            filt_cnt_r <= 16'h0000;
        end else if ((state_r == IDLE) && accept_s && filt_s && (filt_cnt_r != 16'hFFFF)) begin
            filt_cnt_r <= filt_cnt_r + 16'h0001;
        end else begin
            filt_cnt_r <= filt_cnt_r;
        end
    end

    assign filtered_cnt = filt_cnt_r;
`else
    assign filtered_cnt = 16'h0000;
`endif

    assign rd_data    = rd_data_r;
    assign rd_valid   = rd_valid_r;
    assign fifo_level = level_r;
    assign fifo_full  = full_r;
    assign fifo_empty = empty_r;

endmodule
